// File: rtl/reg_bus_sequencer_pkg.sv
// Shared types for the register-bus sequencer: op codes, FSM states and the
// index-width helper used to size register and requester indices.
package reg_seq_pkg;

    typedef enum logic [1:0] {
        OP_MOV = 2'd0,
        OP_LDI = 2'd1,
        OP_CLR = 2'd2,
        OP_RD  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_FIN
    } state_t;

    // A single-entry index still needs one bit to be a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Requester ports, register-bank strobes and the OR-combined bus value.
// master = requesters plus register bank, slave = the sequencer.
interface reg_bus_sequencer_if
    import reg_seq_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int NUM_REQ    = 4
);
    localparam int IDX_W = idx_w(NUM_REGS);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*2-1:0]          req_op;
    logic [NUM_REQ*IDX_W-1:0]      req_src;
    logic [NUM_REQ*IDX_W-1:0]      req_dst;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_imm;
    logic [NUM_REQ-1:0]            done;
    logic                          err;
    logic [WORD_WIDTH-1:0]         rsp_data;
    logic                          rsp_valid;
    logic [NUM_REGS-1:0]           reg_oe;
    logic [NUM_REGS-1:0]           reg_we;
    logic [WORD_WIDTH-1:0]         imm_out;
    logic [WORD_WIDTH-1:0]         bus_in;

    modport master (
        output req_valid, req_op, req_src, req_dst, req_imm, bus_in,
        input  req_ready, done, err, rsp_data, rsp_valid, reg_oe, reg_we, imm_out
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_imm, bus_in,
        output req_ready, done, err, rsp_data, rsp_valid, reg_oe, reg_we, imm_out
    );

endinterface

// File: rtl/reg_bus_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after the
// pointer wins, returned both one-hot and as an index.
module rr_arbiter
    import reg_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    logic          w_found;
    logic [IW-1:0] w_k;

    // NOTE: every signal written here gets a default first, so no path through the loop can infer a latch.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_k = IW'((int'(i_ptr) + i) % N);
            if (!w_found && i_req[w_k]) begin
                w_found    = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Register-bus sequencer: accepts one request round-robin, drives a single
// cycle of registered oe/we/imm strobes, then pulses done to the winner.
module reg_bus_sequencer
    import reg_seq_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic               clk,
    input  logic               rst,
    reg_bus_sequencer_if.slave bus
);
    localparam int IDX_W = idx_w(NUM_REGS);
    localparam int PTR_W = idx_w(NUM_REQ);

    state_t                r_state, w_next_state;
    logic [PTR_W-1:0]      r_ptr, w_idx;
    logic [NUM_REQ-1:0]    r_win, w_gnt;
    op_t                   r_op, w_op;
    logic                  r_bad, w_bad, w_accept;
    logic [IDX_W-1:0]      w_src, w_dst;
    logic [WORD_WIDTH-1:0] w_imm, r_imm, w_imm_nxt, r_rsp_data;
    logic [NUM_REGS-1:0]   r_oe, r_we, w_oe_nxt, w_we_nxt;
    logic                  w_src_bad, w_dst_bad, w_fin;

    rr_arbiter #(.N(NUM_REQ), .IW(PTR_W)) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_op  = op_t'(bus.req_op[w_idx*2 +: 2]);
    assign w_src = bus.req_src[w_idx*IDX_W +: IDX_W];
    assign w_dst = bus.req_dst[w_idx*IDX_W +: IDX_W];
    assign w_imm = bus.req_imm[w_idx*WORD_WIDTH +: WORD_WIDTH];

    // Only the index fields an op actually uses are range checked.
    assign w_src_bad = int'(w_src) >= NUM_REGS;
    assign w_dst_bad = int'(w_dst) >= NUM_REGS;
    assign w_bad     = ((w_op == OP_MOV || w_op == OP_RD) && w_src_bad) ||
                       ((w_op != OP_RD) && w_dst_bad);

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_oe_nxt     = '0;
        w_we_nxt     = '0;
        w_imm_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                    if (!w_bad) begin
                        case (w_op)
                            OP_MOV: begin
                                w_oe_nxt = NUM_REGS'(1) << w_src;
                                w_we_nxt = NUM_REGS'(1) << w_dst;
                            end
                            OP_LDI: begin
                                w_we_nxt  = NUM_REGS'(1) << w_dst;
                                w_imm_nxt = w_imm;
                            end
                            OP_CLR:  w_we_nxt = NUM_REGS'(1) << w_dst;
                            OP_RD:   w_oe_nxt = NUM_REGS'(1) << w_src;
                            default: ;
                        endcase
                    end
                end
            end
            S_EXEC:  w_next_state = S_FIN;
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Strobes are registered in the accept cycle so they are live for EXEC only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_win      <= '0;
            r_op       <= OP_MOV;
            r_bad      <= 1'b0;
            r_oe       <= '0;
            r_we       <= '0;
            r_imm      <= '0;
            r_rsp_data <= '0;
        end else begin
            r_oe  <= w_oe_nxt;
            r_we  <= w_we_nxt;
            r_imm <= w_imm_nxt;
            if (w_accept) begin
                r_win <= w_gnt;
                r_op  <= w_op;
                r_bad <= w_bad;
                r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
            end
            if (r_state == S_EXEC && r_op == OP_RD && !r_bad)
                r_rsp_data <= bus.bus_in;
        end
    end

    // Combinational handshake outputs are masked while reset is held.
    assign w_fin         = (r_state == S_FIN) && !rst;
    assign bus.req_ready = (w_accept && !rst) ? w_gnt : '0;
    assign bus.done      = w_fin ? r_win : '0;
    assign bus.err       = w_fin && r_bad;
    assign bus.rsp_valid = w_fin && (r_op == OP_RD) && !r_bad;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.reg_oe    = r_oe;
    assign bus.reg_we    = r_we;
    assign bus.imm_out   = r_imm;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: behavioural register banks on two instances
// (8 and 6 registers), a vector table, hand sequences and a done scoreboard.
module tb_reg_bus_sequencer;
    import reg_seq_pkg::*;

    logic        clk;
    logic        rst;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cycle    = 0;
    logic [15:0] last_rd;

    reg_bus_sequencer_if #(.WORD_WIDTH(16), .NUM_REGS(8), .NUM_REQ(4)) if8 ();
    reg_bus_sequencer_if #(.WORD_WIDTH(16), .NUM_REGS(6), .NUM_REQ(4)) if6 ();

    reg_bus_sequencer #(.WORD_WIDTH(16), .NUM_REGS(8), .NUM_REQ(4)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    reg_bus_sequencer #(.WORD_WIDTH(16), .NUM_REGS(6), .NUM_REQ(4)) u_dut6 (
        .clk (clk),
        .rst (rst),
        .bus (if6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Register banks: outputs gated by oe, OR-ed with imm_out onto the bus.
    logic [15:0] bank8 [8];
    logic [15:0] bank6 [6];
    logic [15:0] bus8, bus6;
    logic        pl8, pl6;
    logic [2:0]  pl_idx;
    logic [15:0] pl_val;

    always_comb begin
        bus8 = if8.imm_out;
        for (int i = 0; i < 8; i++) if (if8.reg_oe[i]) bus8 = bus8 | bank8[i];
    end
    always_comb begin
        bus6 = if6.imm_out;
        for (int i = 0; i < 6; i++) if (if6.reg_oe[i]) bus6 = bus6 | bank6[i];
    end
    assign if8.bus_in = bus8;
    assign if6.bus_in = bus6;

    always @(posedge clk) begin
        if (pl8) bank8[pl_idx] <= pl_val;
        if (pl6) bank6[pl_idx] <= pl_val;
        for (int i = 0; i < 8; i++) if (if8.reg_we[i]) bank8[i] <= bus8;
        for (int i = 0; i < 6; i++) if (if6.reg_we[i]) bank6[i] <= bus6;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic preload(input logic to6, input logic [2:0] idx, input logic [15:0] val);
        pl8    = !to6;
        pl6    = to6;
        pl_idx = idx;
        pl_val = val;
        @(posedge clk); #1;
        pl8 = 1'b0;
        pl6 = 1'b0;
    endtask

    // Scoreboard of expected FIN-cycle results for the 8-register instance.
    typedef struct {
        logic [3:0]  done;
        logic        rsp_valid;
        logic [15:0] rsp;
    } sb_t;
    sb_t sb8[$];
    sb_t mon_e;

    always @(negedge clk) begin
        if (if8.done != 4'd0 || if8.err || if8.rsp_valid) begin
            if (sb8.size() == 0) begin
                check("unexpected_done", {26'd0, if8.done, if8.err, if8.rsp_valid}, 32'd0);
            end else begin
                mon_e = sb8.pop_front();
                check("done", 32'(if8.done), 32'(mon_e.done));
                check("err", 32'(if8.err), 32'd0);
                check("rsp_valid", 32'(if8.rsp_valid), 32'(mon_e.rsp_valid));
                if (mon_e.rsp_valid) check("rsp_data", 32'(if8.rsp_data), 32'(mon_e.rsp));
            end
        end
    end

    typedef struct {
        int          req;
        logic [1:0]  op;
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [15:0] imm;
        logic [7:0]  oe;
        logic [7:0]  we;
        logic [15:0] imm_o;
        int          reg_idx;
        logic [15:0] reg_val;
        logic        rd;
        logic [15:0] rsp;
    } vec_t;
    vec_t vecs[8];

    task automatic wait_ready8();
        int n = 0;
        @(negedge clk);
        while (if8.req_ready == 4'd0 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic set_req8(input int r, input logic [1:0] op, input logic [2:0] src,
                            input logic [2:0] dst, input logic [15:0] imm);
        if8.req_op[r*2 +: 2]   = op;
        if8.req_src[r*3 +: 3]  = src;
        if8.req_dst[r*3 +: 3]  = dst;
        if8.req_imm[r*16 +: 16] = imm;
    endtask

    // Called just after a rising edge with the sequencer idle.
    task automatic run_vec(input vec_t v);
        set_req8(v.req, v.op, v.src, v.dst, v.imm);
        if8.req_valid[v.req] = 1'b1;
        wait_ready8();
        check("ready", 32'(if8.req_ready), 32'(1) << v.req);
        sb8.push_back('{done: 4'(1 << v.req), rsp_valid: v.rd, rsp: v.rsp});
        @(posedge clk); #1;
        if8.req_valid[v.req] = 1'b0;
        @(negedge clk);
        check("exec_oe", 32'(if8.reg_oe), 32'(v.oe));
        check("exec_we", 32'(if8.reg_we), 32'(v.we));
        check("exec_imm", 32'(if8.imm_out), 32'(v.imm_o));
        @(negedge clk);
        check("fin_strobes", {if8.reg_oe, if8.reg_we, if8.imm_out}, 32'd0);
        check("reg_value", 32'(bank8[v.reg_idx]), 32'(v.reg_val));
        if (v.rd) last_rd = v.rsp;
        check("rsp_hold", 32'(if8.rsp_data), 32'(last_rd));
        @(posedge clk); #1;
    endtask

    // 6-register instance, requester 0; R1 holds 0x5555 throughout.
    task automatic run6(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                        input logic [5:0] e_oe, input logic [5:0] e_we, input logic e_err,
                        input logic [15:0] e_r5);
        int n = 0;
        if6.req_op[1:0]   = op;
        if6.req_src[2:0]  = src;
        if6.req_dst[2:0]  = dst;
        if6.req_imm[15:0] = 16'hFFFF;
        if6.req_valid[0]  = 1'b1;
        @(negedge clk);
        while (if6.req_ready == 4'd0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("r6_ready", 32'(if6.req_ready), 32'd1);
        @(posedge clk); #1;
        if6.req_valid[0] = 1'b0;
        @(negedge clk);
        check("r6_exec_oe", 32'(if6.reg_oe), 32'(e_oe));
        check("r6_exec_we", 32'(if6.reg_we), 32'(e_we));
        check("r6_exec_imm", 32'(if6.imm_out), 32'(op == OP_LDI && !e_err ? 16'hFFFF : 16'h0));
        @(negedge clk);
        check("r6_done", 32'(if6.done), 32'd1);
        check("r6_err", 32'(if6.err), 32'(e_err));
        check("r6_rsp_valid", 32'(if6.rsp_valid), 32'(op == OP_RD && !e_err));
        check("r6_r1", 32'(bank6[1]), 32'h5555);
        check("r6_r5", 32'(bank6[5]), 32'(e_r5));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int last;
        rst = 1'b1;
        pl8 = 1'b0; pl6 = 1'b0; pl_idx = '0; pl_val = '0;
        last_rd = 16'h0;
        if8.req_valid = '0; if8.req_op = '0; if8.req_src = '0; if8.req_dst = '0; if8.req_imm = '0;
        if6.req_valid = '0; if6.req_op = '0; if6.req_src = '0; if6.req_dst = '0; if6.req_imm = '0;

        //          req op      src   dst   imm       oe     we     imm_o     reg val       rd    rsp
        vecs[0] = '{0, OP_MOV, 3'd2, 3'd5, 16'h0000, 8'h04, 8'h20, 16'h0000, 5, 16'h1234, 1'b0, 16'h0000};
        vecs[1] = '{1, OP_LDI, 3'd7, 3'd3, 16'hBEEF, 8'h00, 8'h08, 16'hBEEF, 3, 16'hBEEF, 1'b0, 16'h0000};
        vecs[2] = '{1, OP_CLR, 3'd7, 3'd3, 16'hFFFF, 8'h00, 8'h08, 16'h0000, 3, 16'h0000, 1'b0, 16'h0000};
        vecs[3] = '{2, OP_RD,  3'd7, 3'd2, 16'hFFFF, 8'h80, 8'h00, 16'h0000, 7, 16'h00A5, 1'b1, 16'h00A5};
        vecs[4] = '{3, OP_MOV, 3'd5, 3'd5, 16'h0000, 8'h20, 8'h20, 16'h0000, 5, 16'h1234, 1'b0, 16'h0000};
        vecs[5] = '{0, OP_RD,  3'd5, 3'd0, 16'h0000, 8'h20, 8'h00, 16'h0000, 5, 16'h1234, 1'b1, 16'h1234};
        vecs[6] = '{3, OP_LDI, 3'd7, 3'd0, 16'h8001, 8'h00, 8'h01, 16'h8001, 0, 16'h8001, 1'b0, 16'h0000};
        vecs[7] = '{2, OP_MOV, 3'd0, 3'd7, 16'h0000, 8'h01, 8'h80, 16'h0000, 7, 16'h8001, 1'b0, 16'h0000};

        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
            preload(1'b0, 3'(i), (i == 2) ? 16'h1234 : (i == 7) ? 16'h00A5 : 16'h0000);
        for (int i = 0; i < 6; i++)
            preload(1'b1, 3'(i), (i == 1) ? 16'h5555 : 16'h0000);

        // A request held through reset must not be acknowledged.
        set_req8(0, OP_MOV, 3'd2, 3'd5, 16'h0);
        if8.req_valid[0] = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(if8.req_ready), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_err", 32'(if8.err), 32'd0);
        check("rst_rsp_valid", 32'(if8.rsp_valid), 32'd0);
        check("rst_oe", 32'(if8.reg_oe), 32'd0);
        check("rst_we", 32'(if8.reg_we), 32'd0);
        check("rst_imm", 32'(if8.imm_out), 32'd0);
        check("rst_rsp_data", 32'(if8.rsp_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during EXEC drops the op and returns the pointer to 0.
        set_req8(1, OP_MOV, 3'd2, 3'd4, 16'h0);
        if8.req_valid[1] = 1'b1;
        wait_ready8();
        check("pre_rst_ready", 32'(if8.req_ready), 32'h2);
        @(posedge clk); #1;
        if8.req_valid[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 16'h0;
        @(negedge clk);
        check("post_rst_outputs", {if8.req_ready, if8.done, if8.err, if8.rsp_valid,
                                   if8.reg_oe, if8.reg_we}, 32'd0);
        check("post_rst_imm", 32'(if8.imm_out), 32'd0);
        check("post_rst_rsp_data", 32'(if8.rsp_data), 32'd0);
        @(posedge clk); #1;
        set_req8(0, OP_LDI, 3'd0, 3'd6, 16'h0C0C);
        set_req8(3, OP_LDI, 3'd0, 3'd1, 16'h3333);
        if8.req_valid = 4'b1001;
        wait_ready8();
        check("post_rst_grant", 32'(if8.req_ready), 32'h1);
        sb8.push_back('{done: 4'h1, rsp_valid: 1'b0, rsp: 16'h0});
        @(posedge clk); #1;
        if8.req_valid[0] = 1'b0;
        wait_ready8();
        check("held_grant", 32'(if8.req_ready), 32'h8);
        sb8.push_back('{done: 4'h8, rsp_valid: 1'b0, rsp: 16'h0});
        @(posedge clk); #1;
        if8.req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("ldi_after_rst", 32'(bank8[6]), 32'h0C0C);

        // All four requesters held valid: pointer is 0 here.
        for (int r = 0; r < 4; r++) set_req8(r, OP_LDI, 3'd0, 3'(r), 16'h1000 + 16'(r));
        if8.req_valid = 4'hF;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ready8();
            check("rr_grant", 32'(if8.req_ready), 32'(1) << (g % 4));
            if (g > 0) check("rr_spacing", 32'(cycle - last), 32'd3);
            last = cycle;
            sb8.push_back('{done: 4'(1 << (g % 4)), rsp_valid: 1'b0, rsp: 16'h0});
        end
        @(posedge clk); #1;
        if8.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rr_r2", 32'(bank8[2]), 32'h1002);

        // Out-of-range indices on the 6-register instance.
        run6(OP_MOV, 3'd1, 3'd7, 6'h00, 6'h00, 1'b1, 16'h0000);
        run6(OP_LDI, 3'd0, 3'd6, 6'h00, 6'h00, 1'b1, 16'h0000);
        run6(OP_RD,  3'd6, 3'd0, 6'h00, 6'h00, 1'b1, 16'h0000);
        run6(OP_MOV, 3'd1, 3'd5, 6'h02, 6'h20, 1'b0, 16'h5555);

        n = sb8.size();
        check("sb_drained", 32'(n), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
